// File: rtl/ehl_mem_pkg.sv
// Shared definitions for the single-port-RAM sharing wrappers.
//   arb_state_e   : init FSM states (ST_INIT sweeps the RAM, ST_RUN arbitrates)
//   ID_W          : width of the requester id carried through the read-return pipe
//   rd_latency_ok : legal-range test for the RAM read latency (1..4)
package ehl_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int ID_W       = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ehl_rr_arb2.sv
// Two-way round-robin arbiter with its last-grant pointer.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   req0_i, req1_i   : requests
//   gnt0_o, gnt1_o   : combinational grants, at most one high
// The pointer remembers the last port served (reset value 1, so port 0 wins
// the first conflict) and moves on every grant, contested or not.
module ehl_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic last_q, last_d;

  always_comb begin
    gnt0_o = req0_i & (~req1_i | last_q);
    gnt1_o = req1_i & ~gnt0_o;
    last_d = last_q;
    if (gnt0_o) begin
      last_d = 1'b0;
    end else if (gnt1_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ehl_spram_arb2.sv
// Shares one single-port RAM between two generic request ports.
// Optional feature macro: EHL_SPRAM_ARB2_INIT_EN (sweep INIT_VALUE into every
// word after reset before accepting requests).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req*/wr*/adr*/wdata*         : requester side, held stable until gnt*
//   gnt*                         : combinational accept
//   rvalid*/rdata*               : read return, RD_LATENCY cycles after the grant
//   init_done                    : arbiter is accepting requests
//   mem_wr/mem_oe/mem_adr/mem_din: RAM command, mem_dout: RAM read data
module ehl_spram_arb2 import ehl_mem_pkg::*; #(
  parameter int                AWIDTH     = 10,
  parameter int                DWIDTH     = 32,
  parameter int                RD_LATENCY = 1,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [AWIDTH-1:0] adr0,
  input  logic [AWIDTH-1:0] adr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              init_done,
  output logic              mem_wr,
  output logic              mem_oe,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("ehl_spram_arb2: RD_LATENCY %0d outside 1..4", RD_LATENCY);
  end

  logic              init_act;
  logic [AWIDTH-1:0] init_adr;
  logic              accept;
  logic [AWIDTH-1:0] adr_hold_q;
  logic [DWIDTH-1:0] din_hold_q;

`ifdef EHL_SPRAM_ARB2_INIT_EN
  arb_state_e        state_q, state_d;
  logic [AWIDTH-1:0] init_adr_q, init_adr_d;

  always_comb begin
    state_d    = state_q;
    init_adr_d = init_adr_q;
    if (state_q == ST_INIT) begin
      init_adr_d = init_adr_q + 1'b1;
      if (&init_adr_q) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_adr_q <= init_adr_d;
    end
  end

  assign init_act  = reset_n & (state_q == ST_INIT);
  assign init_done = (state_q == ST_RUN);
  assign init_adr  = init_adr_q;
`else
  assign init_act  = 1'b0;
  assign init_done = 1'b1;
  assign init_adr  = '0;
`endif

  // Requests are masked (not just the grants) so the pointer stays put while
  // the arbiter is in reset or sweeping.
  assign accept = reset_n & init_done;

  ehl_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0_i  (req0 & accept),
    .req1_i  (req1 & accept),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1)
  );

  // Address/data hold their last driven value on idle cycles.
  always_comb begin
    mem_wr  = 1'b0;
    mem_oe  = 1'b0;
    mem_adr = adr_hold_q;
    mem_din = din_hold_q;
    if (init_act) begin
      mem_wr  = 1'b1;
      mem_adr = init_adr;
      mem_din = INIT_VALUE;
    end else if (gnt0) begin
      mem_wr  = wr0;
      mem_oe  = ~wr0;
      mem_adr = adr0;
      mem_din = wdata0;
    end else if (gnt1) begin
      mem_wr  = wr1;
      mem_oe  = ~wr1;
      mem_adr = adr1;
      mem_din = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    adr_hold_q <= mem_adr;
    din_hold_q <= mem_din;
  end

  // Read-return pipe: stage 0 captures the issuing cycle, the last stage
  // lines up with valid mem_dout.
  logic                  issue_vld;
  logic [ID_W-1:0]       issue_id;
  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [ID_W-1:0]       rd_id_q [RD_LATENCY];

  assign issue_vld = (gnt0 & ~wr0) | (gnt1 & ~wr1);
  assign issue_id  = ID_W'(gnt1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= issue_vld;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_id_q[0] <= issue_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_id_q[i] <= rd_id_q[i-1];
    end
  end

  assign rvalid0 = rd_vld_q[RD_LATENCY-1] & (rd_id_q[RD_LATENCY-1] == ID_W'(0));
  assign rvalid1 = rd_vld_q[RD_LATENCY-1] & (rd_id_q[RD_LATENCY-1] == ID_W'(1));
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;

endmodule

// File: tb/tb_ehl_spram_arb2.sv
module tb_ehl_spram_arb2;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int NW  = 1 << AW;
  localparam logic [DW-1:0] IV = 32'h0000_DEAD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0, req1, wr0, wr1;
  logic [AW-1:0] adr0, adr1, mem_adr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_din, mem_dout;
  logic gnt0, gnt1, rvalid0, rvalid1, init_done, mem_wr, mem_oe;

  always #5 clk = ~clk;

  ehl_spram_arb2 #(.AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(LAT), .INIT_VALUE(IV)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
    .mem_wr(mem_wr), .mem_oe(mem_oe), .mem_adr(mem_adr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Environment RAM with one cycle of read latency.
  logic [DW-1:0] sram [NW];
  logic [DW-1:0] dout_q;
  assign mem_dout = dout_q;
  always @(posedge clk) begin
    if (mem_wr) sram[mem_adr] <= mem_din;
    if (mem_oe) dout_q <= sram[mem_adr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t exp_q[$];

  // Reference state: memory contents, last port served, last driven address/data.
  logic [DW-1:0] ref_mem [NW];
  int            last_port;
  logic [AW-1:0] hold_adr;
  logic [DW-1:0] hold_din;
  bit            hold_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the expected read return whenever the DUT presents one.
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (rvalid0 || rvalid1) begin
        chk("rvalid_excl", 64'(rvalid0 & rvalid1), 0);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", {rvalid1, rvalid0}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_port", rvalid1 ? 1 : 0, e.port);
          chk("rdata", rvalid1 ? rdata1 : rdata0, e.data);
          chk("rvalid_cycle", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("rvalid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One request cycle: drive, check grant and RAM command against the rules,
  // then update the reference state and push any expected read return.
  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic g0, output logic g1);
    logic e0, e1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int who;
    @(negedge clk);
    req0 = r0; wr0 = w0; adr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; adr1 = a1; wdata1 = d1;
    #1;
    // A conflict goes to whichever port was not served most recently.
    e0 = r0 && (!r1 || last_port == 1);
    e1 = r1 && !e0;
    chk("gnt", {gnt1, gnt0}, {e1, e0});
    g0 = gnt0;
    g1 = gnt1;
    if (e0 || e1) begin
      who = e1 ? 1 : 0;
      w = e1 ? w1 : w0;
      a = e1 ? a1 : a0;
      d = e1 ? d1 : d0;
      chk("mem_ctl", {mem_wr, mem_oe}, {w, !w});
      chk("mem_adr", mem_adr, a);
      chk("mem_din", mem_din, d);
      if (w) ref_mem[a] = d;
      else exp_q.push_back('{who, ref_mem[a], cyc + LAT});
      last_port = who;
      hold_adr = a;
      hold_din = d;
      hold_ok = 1;
    end else begin
      chk("mem_idle", {mem_wr, mem_oe}, 0);
      if (hold_ok) chk("mem_hold", {mem_adr, mem_din}, {hold_adr, hold_din});
    end
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
  endtask

  task automatic init_phase();
`ifdef EHL_SPRAM_ARB2_INIT_EN
    req0 = 1; wr0 = 0; adr0 = 3;
    for (int i = 0; i < NW; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("init_done_low", init_done, 0);
      chk("init_gnt", {gnt1, gnt0}, 0);
      chk("init_mem", {mem_wr, mem_oe, mem_adr, mem_din}, {2'b10, AW'(i), IV});
    end
    @(negedge clk);
    req0 = 0;
    #1;
    chk("init_done_high", init_done, 1);
    for (int i = 0; i < NW; i++) ref_mem[i] = IV;
    hold_adr = AW'(NW - 1);
    hold_din = IV;
    hold_ok = 1;
`else
    #1;
    chk("init_done", init_done, 1);
`endif
  endtask

  task automatic do_reset(input int n);
    reset_n = 0;
    req0 = 0; req1 = 0;
    exp_q.delete();
    last_port = 1;
    hold_ok = 0;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_mem", {mem_wr, mem_oe}, 0);
    @(negedge clk);
    reset_n = 1;
    init_phase();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;
    int n0, n1;
    logic [3:0] seq;
    bit p [2];
    logic pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic pg [2];
    int wait_c [2];
    int max_wait;

    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
    last_port = 1; hold_ok = 0; hold_adr = '0; hold_din = '0;
    for (int i = 0; i < NW; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end

    // Release briefly then reset again, so an interrupted sweep must restart.
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    do_reset(2);

    // Both ports request continuously for 4 cycles.
    n0 = 0; n1 = 0; seq = '0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 4'd1, '0, 1, 0, 4'd2, '0, g0, g1);
      n0 += int'(g0);
      n1 += int'(g1);
      seq[k] = g1;
    end
    chk("contest_seq", seq, 4'b1010);
    chk("contest_cnt0", n0, 2);
    chk("contest_cnt1", n1, 2);

    // Sole requester: write then read back.
    drive(1, 1, 4'd5, 32'hA5A5_0005, 0, 0, '0, '0, g0, g1);
    drive(1, 0, 4'd5, '0, 0, 0, '0, '0, g0, g1);
    chk("sole_gnt", g0, 1);
    idle(1);
    chk("sole_rvalid", rvalid0, 1);
    chk("sole_rdata", rdata0, 32'hA5A5_0005);

    // Mixed back-to-back reads from alternating ports.
    drive(1, 0, 4'd1, '0, 0, 0, '0, '0, g0, g1);
    drive(0, 0, '0, '0, 1, 0, 4'd2, '0, g0, g1);
    idle(2);

    // Conflicting read/write on the same word, port 0 wins (read sees old value).
    drive(1, 0, 4'd7, '0, 1, 1, 4'd7, 32'h0000_1234, g0, g1);
    chk("rw_first_winner", {g1, g0}, 2'b01);
    drive(0, 0, '0, '0, 1, 1, 4'd7, 32'h0000_1234, g0, g1);
    // Port 0 served alone first, so port 1 wins the conflict (read sees new value).
    drive(1, 0, 4'd0, '0, 0, 0, '0, '0, g0, g1);
    drive(1, 0, 4'd7, '0, 1, 1, 4'd7, 32'h0000_5678, g0, g1);
    chk("rw_second_winner", {g1, g0}, 2'b10);
    drive(1, 0, 4'd7, '0, 0, 0, '0, '0, g0, g1);
    idle(2);

    // Reset lands with a read in flight; nothing may return.
    drive(0, 0, '0, '0, 1, 0, 4'd3, '0, g0, g1);
    @(posedge clk);
    #1;
    do_reset(2);
    drive(1, 0, 4'd4, '0, 1, 0, 4'd9, '0, g0, g1);
    chk("post_rst_winner", {g1, g0}, 2'b01);
    idle(2);

    // Randomised traffic with requests held until granted (or dropped).
    max_wait = 0;
    for (int i = 0; i < 2; i++) begin
      p[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; wait_c[i] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            p[i] = 1;
            pw[i] = ($urandom_range(0, 4) < 2);
            pa[i] = AW'($urandom);
            pd[i] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          p[i] = 0;
          wait_c[i] = 0;
        end
      end
      drive(p[0], pw[0], pa[0], pd[0], p[1], pw[1], pa[1], pd[1], g0, g1);
      pg[0] = g0;
      pg[1] = g1;
      for (int i = 0; i < 2; i++) begin
        if (p[i]) begin
          if (pg[i]) begin
            p[i] = 0;
            wait_c[i] = 0;
          end else begin
            wait_c[i]++;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
          end
        end
      end
    end
    idle(LAT + 3);
    chk("queue_drained", exp_q.size(), 0);
    chk("fair_max_wait", 64'(max_wait <= 1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
